// File: rtl/usb_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// usb_reset_sequencer_if
//   Avalon-MM slave bus bundle for the USB reset sequencer.
//
//   address     [1:0]   word address (CTRL, STATUS, ASSERT_CYCLES, RECOVER_CYCLES)
//   chipselect          slave select
//   write_n             active-low write strobe
//   writedata   [31:0]  write data
//   readdata    [31:0]  combinational, zero-latency read data
//
//   master : bus master side (Nios II / interconnect / testbench)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface usb_reset_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/usb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// usb_reset_sequencer
//   Generates the timed hardware reset sequence for the on-board USB host
//   controller: hold usb_rst_n low for ASSERT_CYCLES clocks, release it and
//   wait RECOVER_CYCLES clocks, then flag DONE (and interrupt if enabled).
//   Optionally runs one sequence straight out of system reset.
//
// Ports
//   clk        system clock (50 MHz)
//   reset_n    asynchronous active-low reset
//   bus        Avalon-MM slave (usb_reset_sequencer_if.slave)
//   usb_rst_n  registered active-low reset to the USB chip
//   irq        level interrupt, DONE & IRQ_EN
//
// Register map (word addresses)
//   0 CTRL           W: bit0 START (pulse), bit1 IRQ_EN, bit2 ABORT (pulse)
//                    R: bit1 IRQ_EN
//   1 STATUS         R: bit0 BUSY, bit1 DONE, bits3:2 state (0 IDLE,
//                       1 ASSERT, 2 RECOVER); W: bit1=1 clears DONE
//   2 ASSERT_CYCLES  R/W [15:0]
//   3 RECOVER_CYCLES R/W [15:0]
// ---------------------------------------------------------------------------
module usb_reset_sequencer #(
  parameter int          AUTO_START      = 1,
  parameter logic [15:0] ASSERT_DEFAULT  = 16'd5000,
  parameter logic [15:0] RECOVER_DEFAULT = 16'd50000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  usb_reset_sequencer_if.slave bus,
  output logic                 usb_rst_n,
  output logic                 irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_ASSERT  = 2'd2;
  localparam logic [1:0] ADDR_RECOVER = 2'd3;

  // A zero length would never expire on the ==1 test, so it is run as one
  // clock instead.
  function automatic logic [15:0] load_len(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

  localparam state_t      RESET_STATE = (AUTO_START != 0) ? ST_ASSERT : ST_IDLE;
  localparam logic [15:0] RESET_COUNT = load_len(ASSERT_DEFAULT);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] assert_cycles;
  logic [15:0] recover_cycles;
  logic        irq_en;
  logic        done;
  logic        usb_rst_n_q;

  logic        wr;
  logic        ctrl_wr;
  logic        start;
  logic        abort;
  logic        busy;

  // Only the low half of writedata carries register content.
  logic        unused_wdata;
  assign unused_wdata = ^bus.writedata[31:16];

  assign wr      = bus.chipselect & ~bus.write_n;
  assign ctrl_wr = wr & (bus.address == ADDR_CTRL);
  assign start   = ctrl_wr & bus.writedata[0];
  assign abort   = ctrl_wr & bus.writedata[2];
  assign busy    = (state != ST_IDLE);

  assign usb_rst_n = usb_rst_n_q;
  assign irq       = done & irq_en;

  // Register file and sequencing FSM. The counter holds the remaining clocks
  // of the current timed state; a state exits on the edge where it reads 1,
  // so a value N loaded on entry yields exactly N clocks in that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RESET_STATE;
      cnt            <= RESET_COUNT;
      assert_cycles  <= ASSERT_DEFAULT;
      recover_cycles <= RECOVER_DEFAULT;
      irq_en         <= 1'b0;
      done           <= 1'b0;
      usb_rst_n_q    <= 1'b0;
    end else begin
      if (ctrl_wr)
        irq_en <= bus.writedata[1];
      if (wr && bus.address == ADDR_ASSERT)
        assert_cycles <= bus.writedata[15:0];
      if (wr && bus.address == ADDR_RECOVER)
        recover_cycles <= bus.writedata[15:0];

      // W1C first so a completion on the same edge overrides the clear.
      if (wr && bus.address == ADDR_STATUS && bus.writedata[1])
        done <= 1'b0;

      if (abort) begin
        // ABORT takes priority over a START carried in the same write.
        state       <= ST_IDLE;
        usb_rst_n_q <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            usb_rst_n_q <= 1'b1;
            if (start) begin
              state       <= ST_ASSERT;
              cnt         <= load_len(assert_cycles);
              usb_rst_n_q <= 1'b0;
            end
          end
          ST_ASSERT: begin
            if (cnt == 16'd1) begin
              state       <= ST_RECOVER;
              cnt         <= load_len(recover_cycles);
              usb_rst_n_q <= 1'b1;
            end else begin
              cnt         <= cnt - 16'd1;
              usb_rst_n_q <= 1'b0;
            end
          end
          ST_RECOVER: begin
            usb_rst_n_q <= 1'b1;
            if (cnt == 16'd1) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          default: begin
            state       <= ST_IDLE;
            usb_rst_n_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Zero-latency read mux; reads have no side effects.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      ADDR_CTRL:    bus.readdata = {30'd0, irq_en, 1'b0};
      ADDR_STATUS:  bus.readdata = {28'd0, state, done, busy};
      ADDR_ASSERT:  bus.readdata = {16'd0, assert_cycles};
      ADDR_RECOVER: bus.readdata = {16'd0, recover_cycles};
      default:      bus.readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_usb_reset_sequencer.sv
module tb_usb_reset_sequencer;

  logic clk;
  logic reset_n;
  logic usb_rst_n;
  logic irq;
  int   checks;
  int   errors;
  logic [31:0] d;

  usb_reset_sequencer_if bus ();

  usb_reset_sequencer #(
    .AUTO_START      (1),
    .ASSERT_DEFAULT  (16'd4),
    .RECOVER_DEFAULT (16'd6)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .usb_rst_n (usb_rst_n),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; the write lands on the following posedge and the
  // task returns at the negedge after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.address    = a;
    bus.writedata  = v;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    v = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (usb_rst_n !== 1'b0) begin errors++; $display("FAIL reset_usb_rst_n got %b want 0", usb_rst_n); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    rd(2'd1, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL reset_status got %h want 00000005", d); end
    @(negedge clk);
    rd(2'd2, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL reset_assert_cycles got %h want 4", d); end
    rd(2'd3, d);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL reset_recover_cycles got %h want 6", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
    @(negedge clk);
  endtask

  // Release after edge 0: low through edge 3, high from edge 4, DONE at edge 10.
  task automatic test_auto_start;
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (usb_rst_n !== (k >= 4)) begin errors++; $display("FAIL auto_usb_rst_n edge %0d got %b want %b", k, usb_rst_n, (k >= 4)); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL auto_irq edge %0d got %b want 0", k, irq); end
      if (k == 9) begin
        rd(2'd1, d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL auto_status_recover got %h want 00000009", d); end
      end
      if (k == 10) begin
        rd(2'd1, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL auto_status_done got %h want 00000002", d); end
      end
    end
  endtask

  task automatic test_basic;
    @(negedge clk);
    wr(2'd1, 32'h2);
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_w1c_pre got %h want 0", d); end
    @(negedge clk);
    wr(2'd2, 32'd3);
    wr(2'd3, 32'd2);
    wr(2'd0, 32'h3);
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (usb_rst_n !== (k >= 3)) begin errors++; $display("FAIL basic_usb_rst_n T+%0d got %b want %b", k, usb_rst_n, (k >= 3)); end
      checks++;
      if (irq !== (k == 5)) begin errors++; $display("FAIL basic_irq T+%0d got %b want %b", k, irq, (k == 5)); end
    end
    rd(2'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_status_done got %h want 00000002", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_ctrl_read got %h want 00000002", d); end
    @(negedge clk);
    wr(2'd1, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_cleared got %b want 0", irq); end
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_status_cleared got %h want 0", d); end
    @(negedge clk);
  endtask

  task automatic test_zero_length;
    wr(2'd2, 32'd0);
    wr(2'd3, 32'd0);
    wr(2'd0, 32'h3);
    checks++; if (usb_rst_n !== 1'b0) begin errors++; $display("FAIL zero_usb_rst_n T got %b want 0", usb_rst_n); end
    @(negedge clk);
    checks++; if (usb_rst_n !== 1'b1) begin errors++; $display("FAIL zero_usb_rst_n T+1 got %b want 1", usb_rst_n); end
    rd(2'd1, d);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL zero_status T+1 got %h want 00000009", d); end
    @(negedge clk);
    rd(2'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL zero_status T+2 got %h want 00000002", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL zero_irq T+2 got %b want 1", irq); end
    @(negedge clk);
    wr(2'd1, 32'h2);
  endtask

  task automatic test_busy_writes;
    wr(2'd2, 32'd5);
    wr(2'd3, 32'd2);
    wr(2'd0, 32'h3);               // edge T
    @(negedge clk);                // T+1
    wr(2'd0, 32'h3);               // START again at T+2, ignored
    wr(2'd2, 32'd100);             // T+3
    checks++; if (usb_rst_n !== 1'b0) begin errors++; $display("FAIL busy_usb_rst_n T+3 got %b want 0", usb_rst_n); end
    rd(2'd2, d);
    checks++; if (d !== 32'd100) begin errors++; $display("FAIL busy_assert_readback got %h want 00000064", d); end
    @(negedge clk);
    checks++; if (usb_rst_n !== 1'b0) begin errors++; $display("FAIL busy_usb_rst_n T+4 got %b want 0", usb_rst_n); end
    @(negedge clk);
    checks++; if (usb_rst_n !== 1'b1) begin errors++; $display("FAIL busy_usb_rst_n T+5 got %b want 1", usb_rst_n); end
    repeat (2) @(negedge clk);
    rd(2'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL busy_status T+7 got %h want 00000002", d); end
    @(negedge clk);
    wr(2'd1, 32'h2);
    wr(2'd0, 32'h3);               // edge T'
    repeat (99) @(negedge clk);
    checks++; if (usb_rst_n !== 1'b0) begin errors++; $display("FAIL long_usb_rst_n T+99 got %b want 0", usb_rst_n); end
    @(negedge clk);
    checks++; if (usb_rst_n !== 1'b1) begin errors++; $display("FAIL long_usb_rst_n T+100 got %b want 1", usb_rst_n); end
    repeat (2) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL long_irq T+102 got %b want 1", irq); end
    wr(2'd1, 32'h2);
  endtask

  task automatic test_abort;
    wr(2'd2, 32'd3);
    wr(2'd3, 32'd10);
    wr(2'd0, 32'h3);               // edge T
    repeat (5) @(negedge clk);     // T+5, in RECOVER
    rd(2'd1, d);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL abort_pre_status got %h want 00000009", d); end
    @(negedge clk);
    wr(2'd0, 32'h5);               // ABORT + START at T+7
    checks++; if (usb_rst_n !== 1'b1) begin errors++; $display("FAIL abort_recover_usb_rst_n got %b want 1", usb_rst_n); end
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_recover_status got %h want 0", d); end
    repeat (15) @(negedge clk);
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_no_done got %h want 0", d); end
    @(negedge clk);
    wr(2'd0, 32'h1);               // START, ASSERT for 3
    wr(2'd0, 32'h4);               // ABORT during ASSERT
    checks++; if (usb_rst_n !== 1'b1) begin errors++; $display("FAIL abort_assert_usb_rst_n got %b want 1", usb_rst_n); end
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_assert_status got %h want 0", d); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    // From IDLE: the output must fall without any clock edge.
    checks++; if (usb_rst_n !== 1'b1) begin errors++; $display("FAIL async_pre_usb_rst_n got %b want 1", usb_rst_n); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (usb_rst_n !== 1'b0) begin errors++; $display("FAIL async_idle_usb_rst_n got %b want 0", usb_rst_n); end
    @(negedge clk);
    reset_n = 1'b1;                // edge 0 already passed
    @(negedge clk);                // after edge 1, auto ASSERT running
    wr(2'd2, 32'd20);              // edge 2
    wr(2'd0, 32'h2);               // edge 3
    rd(2'd2, d);
    checks++; if (d !== 32'd20) begin errors++; $display("FAIL async_pre_assert got %h want 00000014", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL async_pre_ctrl got %h want 00000002", d); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (usb_rst_n !== 1'b0) begin errors++; $display("FAIL async_assert_usb_rst_n got %b want 0", usb_rst_n); end
    @(negedge clk);
    rd(2'd2, d);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL async_assert_default got %h want 4", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL async_ctrl_default got %h want 0", d); end
    rd(2'd1, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL async_status_default got %h want 00000005", d); end
    @(negedge clk);
  endtask

  // Auto sequence with defaults sets DONE at edge 10; W1C lands on edge 10.
  task automatic test_done_race;
    reset_n = 1'b1;
    repeat (9) @(negedge clk);
    rd(2'd1, d);
    checks++; if (d !== 32'h9) begin errors++; $display("FAIL race_pre_status got %h want 00000009", d); end
    wr(2'd1, 32'h2);
    rd(2'd1, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL race_set_wins got %h want 00000002", d); end
    @(negedge clk);
    wr(2'd1, 32'h2);
    rd(2'd1, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL race_later_clear got %h want 0", d); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset_n        = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_auto_start();
    test_basic();
    test_zero_length();
    test_busy_writes();
    test_abort();
    test_async_reset();
    test_done_race();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
